// File: rtl/qcm_decoder_pkg.sv
// +----------------------------------------------------------------------+
// | qcm_decoder_pkg: shared decoder state encoding and default timings   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package qcm_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_GAP  = 3'd2,
    ST_BITS = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int DEFAULT_THRESHOLD_TIME = 127;
  localparam int DEFAULT_MIN_TAU        = 256;

endpackage

`default_nettype wire

// File: rtl/sig_glitch_filter.sv
// +----------------------------------------------------------------------+
// | sig_glitch_filter: 2-flop synchroniser plus level-persistence filter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sig_glitch_filter
  import qcm_decoder_pkg::*;
#(
  parameter int THRESHOLD_TIME = DEFAULT_THRESHOLD_TIME,
  parameter int TIMER_SIZE     = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sig_f
);

  logic                  sync1_q, sync2_q;
  logic                  sig_f_q, sig_f_d;
  logic [TIMER_SIZE-1:0] cnt_q, cnt_d;

  // The count holds the number of consecutive mismatch cycles already seen.
  always_comb begin
    sig_f_d = sig_f_q;
    cnt_d   = '0;
    if (sync2_q != sig_f_q) begin
      if (cnt_q == TIMER_SIZE'(THRESHOLD_TIME)) begin
        sig_f_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sig_f_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sig;
      sync2_q <= sync1_q;
      sig_f_q <= sig_f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sig_f = sig_f_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_decoder.sv
// +----------------------------------------------------------------------+
// | serial_word_decoder: arm-pulse calibrated serial word recovery       |
// | Optional parity bin enabled by PARITY_CHECK_EN. Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_word_decoder
  import qcm_decoder_pkg::*;
#(
  parameter int NUM_SIZE       = 7,
  parameter int TIMER_SIZE     = 13,
  parameter int THRESHOLD_TIME = DEFAULT_THRESHOLD_TIME,
  parameter int MIN_TAU        = DEFAULT_MIN_TAU
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig,
  output logic [NUM_SIZE-1:0] num_out,
  output logic                num_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int IDX_W = $clog2(NUM_SIZE + 2);
`ifdef PARITY_CHECK_EN
  localparam int NUM_BINS = NUM_SIZE + 1;
`else
  localparam int NUM_BINS = NUM_SIZE;
`endif
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_BINS - 1);
  localparam logic [TIMER_SIZE-1:0] MIN_TAU_C = TIMER_SIZE'(MIN_TAU);
  localparam logic [TIMER_SIZE-1:0] CNT_MAX   = '1;

  logic                  sig_f, sig_f_prev_q;
  logic                  sig_rise, sig_fall;
  state_e                state_q, state_d;
  logic [TIMER_SIZE-1:0] arm_cnt_q, arm_cnt_d;
  logic [TIMER_SIZE-1:0] tau_q, tau_d;
  logic [TIMER_SIZE-1:0] bin_cnt_q, bin_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_SIZE-1:0]   shift_q, shift_d;
  logic [NUM_SIZE-1:0]   num_out_q, num_out_d;
  logic                  num_valid_q, num_valid_d;
  logic                  frame_err_q, frame_err_d;
`ifdef PARITY_CHECK_EN
  logic                  parity_q, parity_d;
`endif

  sig_glitch_filter #(
    .THRESHOLD_TIME (THRESHOLD_TIME),
    .TIMER_SIZE     (TIMER_SIZE)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .sig   (sig),
    .sig_f (sig_f)
  );

  assign sig_rise = sig_f & ~sig_f_prev_q;
  assign sig_fall = ~sig_f & sig_f_prev_q;

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    tau_d       = tau_q;
    bin_cnt_d   = bin_cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    num_out_d   = num_out_q;
    num_valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sig_rise) begin
          state_d   = ST_ARM;
          arm_cnt_d = TIMER_SIZE'(1);
        end
      end
      ST_ARM: begin
        if (sig_fall) begin
          tau_d = arm_cnt_q;
          if ((arm_cnt_q < MIN_TAU_C) || (arm_cnt_q == CNT_MAX)) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            bin_cnt_d = '0;
          end
        end else if (sig_f && (arm_cnt_q != CNT_MAX)) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (bin_cnt_q == tau_q - 1'b1) begin
          state_d   = ST_BITS;
          bin_cnt_d = '0;
          idx_d     = '0;
        end else begin
          bin_cnt_d = bin_cnt_q + 1'b1;
        end
      end
      ST_BITS: begin
        if (bin_cnt_q == (tau_q >> 1)) begin
          for (int i = 0; i < NUM_SIZE; i++) begin
            if (idx_q == IDX_W'(NUM_SIZE - 1 - i)) shift_d[i] = sig_f;
          end
`ifdef PARITY_CHECK_EN
          if (idx_q == IDX_W'(NUM_SIZE)) parity_d = sig_f;
`endif
        end
        if (bin_cnt_q == tau_q - 1'b1) begin
          bin_cnt_d = '0;
          idx_d     = idx_q + 1'b1;
          // Every sample lands at a bin centre, so shift_q is complete here.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
`ifdef PARITY_CHECK_EN
            if (^{shift_q, parity_q}) begin
              frame_err_d = 1'b1;
            end else begin
              num_out_d   = shift_q;
              num_valid_d = 1'b1;
            end
`else
            num_out_d   = shift_q;
            num_valid_d = 1'b1;
`endif
          end
        end else begin
          bin_cnt_d = bin_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sig_f_prev_q <= 1'b0;
      arm_cnt_q    <= '0;
      tau_q        <= TIMER_SIZE'(1);
      bin_cnt_q    <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      num_out_q    <= '0;
      num_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_f_prev_q <= sig_f;
      arm_cnt_q    <= arm_cnt_d;
      tau_q        <= tau_d;
      bin_cnt_q    <= bin_cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      num_out_q    <= num_out_d;
      num_valid_q  <= num_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

  assign num_out   = num_out_q;
  assign num_valid = num_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_word_decoder.sv
// +----------------------------------------------------------------------+
// | tb_serial_word_decoder: directed bench with expected-word scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_serial_word_decoder;

  localparam int NUM_SIZE       = 4;
  localparam int TIMER_SIZE     = 13;
  localparam int THRESHOLD_TIME = 3;
  localparam int MIN_TAU        = 8;
  localparam int TAU            = 20;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sig = 1'b0;
  logic [NUM_SIZE-1:0] num_out;
  logic                num_valid;
  logic                frame_err;
  logic                busy;

  int tests  = 0;
  int fails  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int v0, e0;
  logic [NUM_SIZE-1:0] exp_q[$];
  logic [NUM_SIZE-1:0] sb_exp;

  always #5 clk = ~clk;

  serial_word_decoder #(
    .NUM_SIZE       (NUM_SIZE),
    .TIMER_SIZE     (TIMER_SIZE),
    .THRESHOLD_TIME (THRESHOLD_TIME),
    .MIN_TAU        (MIN_TAU)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .num_out   (num_out),
    .num_valid (num_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    sig = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [NUM_SIZE-1:0] w);
    drive(1'b1, TAU);
    drive(1'b0, TAU);
    for (int i = NUM_SIZE - 1; i >= 0; i--) drive(w[i], TAU);
    drive(1'b0, 40);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic send_parity_frame(input logic [NUM_SIZE-1:0] w, input logic p);
    drive(1'b1, TAU);
    drive(1'b0, TAU);
    for (int i = NUM_SIZE - 1; i >= 0; i--) drive(w[i], TAU);
    drive(p, TAU);
    drive(1'b0, 40);
  endtask
`endif

  // Scoreboard: each num_valid strobe consumes one expected word.
  always @(negedge clk) begin
    if (num_valid) begin
      n_valid++;
      check("valid_err_exclusive", {31'd0, frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_valid: observed %0h expected none", num_out);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_num_out", {28'd0, num_out}, {28'd0, sb_exp});
      end
    end
    if (frame_err) n_err++;
  end

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("rst_num_out",   {28'd0, num_out},   32'd0);
    check("rst_num_valid", {31'd0, num_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst = 1'b0;
    drive(1'b0, 10);

    // Nominal frame
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(4'b1101);
    send_frame(4'b1101);
    check("nom_valid_cnt", n_valid - v0, 1);
    check("nom_err_cnt",   n_err - e0,   0);
    check("nom_num_out",   {28'd0, num_out}, 32'hD);
    check("nom_busy",      {31'd0, busy},    32'd0);
    check("nom_sb_empty",  exp_q.size(),     0);

    // Short arm pulse
    v0 = n_valid; e0 = n_err;
    drive(1'b1, 6);
    drive(1'b0, 30);
    check("short_err_cnt",   n_err - e0,   1);
    check("short_valid_cnt", n_valid - v0, 0);
    check("short_num_out",   {28'd0, num_out}, 32'hD);
    check("short_busy",      {31'd0, busy},    32'd0);

    // High glitch while idle
    v0 = n_valid; e0 = n_err;
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("idle_glitch_err",  n_err - e0, 0);
    check("idle_glitch_busy", {31'd0, busy}, 32'd0);

    // Low glitch inside a 1-bin
    exp_q.push_back(4'b1011);
    drive(1'b1, TAU);
    drive(1'b0, TAU);
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, TAU - 5);
    drive(1'b0, TAU);
    drive(1'b1, TAU);
    drive(1'b1, TAU);
    drive(1'b0, 40);
    check("glitch_valid_cnt", n_valid - v0, 1);
    check("glitch_err_cnt",   n_err - e0,   0);
    check("glitch_num_out",   {28'd0, num_out}, 32'hB);

    // Arm timeout
    v0 = n_valid; e0 = n_err;
    drive(1'b1, 8192);
    check("tmo_busy_while_high", {31'd0, busy}, 32'd1);
    check("tmo_no_early_err",    n_err - e0, 0);
    drive(1'b0, 20);
    check("tmo_err_cnt",   n_err - e0,   1);
    check("tmo_valid_cnt", n_valid - v0, 0);
    check("tmo_busy",      {31'd0, busy}, 32'd0);

    // Reset in the middle of bin 2
    drive(1'b1, TAU);
    drive(1'b0, TAU);
    drive(1'b1, TAU);
    drive(1'b1, TAU);
    drive(1'b0, 5);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_num_out",   {28'd0, num_out},   32'd0);
    check("mid_rst_num_valid", {31'd0, num_valid}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 10);
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(4'b0110);
    send_frame(4'b0110);
    check("post_rst_valid_cnt", n_valid - v0, 1);
    check("post_rst_num_out",   {28'd0, num_out}, 32'h6);
    check("post_rst_busy",      {31'd0, busy},    32'd0);

`ifdef PARITY_CHECK_EN
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(4'b1101);
    send_parity_frame(4'b1101, 1'b1);
    check("par_ok_valid_cnt", n_valid - v0, 1);
    check("par_ok_err_cnt",   n_err - e0,   0);
    check("par_ok_num_out",   {28'd0, num_out}, 32'hD);
    v0 = n_valid; e0 = n_err;
    send_parity_frame(4'b1101, 1'b0);
    check("par_bad_err_cnt",   n_err - e0,   1);
    check("par_bad_valid_cnt", n_valid - v0, 0);
    check("par_bad_num_out",   {28'd0, num_out}, 32'hD);
`endif

    check("sb_final_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_word_decoder.md
# serial_word_decoder

- Parametrised successor to the team's single-channel pulse-width decoder.
- Recovers an N-bit word from one self-clocked serial line: an arm pulse calibrates the bin width, then the data bits are sampled at bin centres.
- Adds what the first-generation block lacks: a reset, input synchronisation, a valid strobe, frame-error detection, range checks on the calibrated width, and an optional parity bin.
- Sits between the board's digital input pin and the phase-delay register logic.

## Interface
- NUM_SIZE, 7, data bits per word, MSB first, 1..16
- TIMER_SIZE, 13, width of the bin and arm counters
- THRESHOLD_TIME, 127, glitch filter: a level must persist THRESHOLD_TIME+1 cycles to be accepted
- MIN_TAU, 256, smallest legal arm-pulse width in cycles; must be ≥ 4
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- sig  input  1  raw serial input, asynchronous to clk
- num_out  output  NUM_SIZE  last good word, held until the next good word
- num_valid  output  1  one-cycle strobe, num_out updated this cycle
- frame_err  output  1  one-cycle strobe, frame rejected
- busy  output  1  high in every state except IDLE

## Operation
- Input path: 2-flop synchroniser, then glitch filter.
  - Filter output sig_f toggles only after the synchronised value has differed from sig_f for THRESHOLD_TIME+1 consecutive cycles.
  - Any mismatch-free cycle clears the filter count.
- States:
  - IDLE: wait for a rising edge on sig_f, then go to ARM with arm_cnt=1.
  - ARM: arm_cnt increments each cycle sig_f is high and saturates at 2^TIMER_SIZE-1. On the falling edge of sig_f, tau is set to arm_cnt.
    - If tau < MIN_TAU or arm_cnt is saturated: pulse frame_err, return to IDLE.
    - Otherwise go to GAP with bin_cnt=0.
  - GAP: bin_cnt counts 0..tau-1. Line level is ignored. Then go to BITS with idx=0 and bin_cnt=0.
  - BITS: bin_cnt counts 0..tau-1.
    - At bin_cnt == tau>>1 (floor), capture sig_f into shift register bit NUM_SIZE-1-idx.
    - At bin_cnt == tau-1, idx increments and bin_cnt clears.
    - After the last bin, go to DONE.
  - DONE (one cycle): load num_out, pulse num_valid, go to IDLE.
- IDLE needs a genuine low→high edge, so a trailing 1-bit that stays high cannot re-arm the block.
- Arithmetic:
  - All counters are unsigned, TIMER_SIZE wide.
  - tau ≥ MIN_TAU ≥ 4, so the centre sample never lands in bin_cnt 0.
  - idx is $clog2(NUM_SIZE+2) bits wide.
- Simultaneous events: inside GAP and BITS, edges on sig_f have no effect on timing. Only the calibrated tau paces bins.
- Reset mid-frame:
  - Aborts the frame immediately.
  - Next edge is treated as the start of a new arm pulse once the filter is requalified.

## Timing
- Reset values:
  - num_out=0, num_valid=0, frame_err=0, busy=0.
  - State IDLE, tau=1, filter and synchroniser set to 0.
- Edge-to-sig_f latency is 2 (synchroniser) + THRESHOLD_TIME+1 cycles. Both edges see the same delay, so tau equals the true pulse width.
- num_valid rises exactly 1 cycle after the final bin's bin_cnt == tau-1 cycle.
- frame_err rises 1 cycle after the ARM-exit falling edge of sig_f.
- num_valid and frame_err are never high in the same cycle.
- busy rises the cycle after the IDLE→ARM transition and falls with the return to IDLE.

## Configuration
- PARITY_CHECK_EN defined:
  - One extra bin follows the LSB; its sample is the parity bit.
  - Word is accepted only if XOR of data bits and parity bit is 0 (even parity).
  - On mismatch: frame_err pulses in the DONE cycle instead of num_valid, and num_out is unchanged.
- PARITY_CHECK_EN undefined: exactly NUM_SIZE bins, and DONE always accepts.

## Structure
- Shared package qcm_decoder_pkg:
  - State enum (IDLE, ARM, GAP, BITS, DONE).
  - Default constants for THRESHOLD_TIME and MIN_TAU.
- Sub-module sig_glitch_filter: synchroniser plus persistence filter, parameters THRESHOLD_TIME and TIMER_SIZE. It is reused by other input pins.

## Test plan
Bench parameters: NUM_SIZE=4, THRESHOLD_TIME=3, MIN_TAU=8, tau=20, parity off unless stated.
- Nominal frame: arm 20 high, gap 20 low, bins 1,1,0,1, then low → num_out=4'b1101, one-cycle num_valid, busy low afterward.
- Short arm pulse: 6-cycle arm → frame_err pulse, num_out keeps its previous value, no num_valid.
- Glitch rejection: 2-cycle low glitch inside a 1-bit bin and 3-cycle high glitch in IDLE → word decodes correctly and IDLE stays idle.
- Arm timeout: sig held high for 2^13 cycles → frame_err once, block returns to IDLE only after sig falls.
- Reset mid-frame: rst asserted during bin 2 → all outputs 0 immediately; following frame 0110 decodes to 4'b0110.
- PARITY_CHECK_EN: data 1101 with parity 1 → num_valid; data 1101 with parity 0 → frame_err, num_out unchanged.
